// File: rtl/hex_scan_ctrl.sv
// Time-multiplexes one external hex-to-7-segment decoder across NUM_DIGITS displays,
// scanning MSD-first and committing each completed frame to hex_out in a single edge.
module hex_scan_ctrl #(
    parameter int unsigned NUM_DIGITS    = 6,
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic                    blank_en,
    input  logic                    load,
    input  logic [6:0]              dec_seg,
    output logic [3:0]              dec_nibble,
    output logic [7*NUM_DIGITS-1:0] hex_out,
    output logic                    busy,
    output logic                    done
);

    localparam int unsigned IDX_W = $clog2(NUM_DIGITS);
    localparam int unsigned CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
    typedef logic [NUM_DIGITS-1:0][3:0] nib_arr_t;
    typedef logic [NUM_DIGITS-1:0][6:0] seg_arr_t;

    state_t          state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic            lead_q, lead_d;
    nib_arr_t        frame_q, frame_d;
    logic            fblank_q, fblank_d;
    logic            pend_q, pend_d;
    nib_arr_t        pval_q, pval_d;
    logic            pblank_q, pblank_d;
    seg_arr_t        stage_q, stage_d;
    seg_arr_t        hex_q, hex_d;
    logic [3:0]      nib_q, nib_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic            start;
    nib_arr_t        start_val;
    logic            start_blank;
    logic [3:0]      cur_nib;

    assign cur_nib = frame_q[idx_q];

    // Next-state, capture/commit and output-register logic.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        lead_d      = lead_q;
        frame_d     = frame_q;
        fblank_d    = fblank_q;
        pend_d      = pend_q;
        pval_d      = pval_q;
        pblank_d    = pblank_q;
        stage_d     = stage_q;
        hex_d       = hex_q;
        start       = 1'b0;
        start_val   = value;
        start_blank = blank_en;

        case (state_q)
            IDLE: begin
                if (load) begin
                    start = 1'b1;
                end
            end
            SCAN: begin
                // Requests during a scan are queued; only the newest survives.
                if (load) begin
                    pend_d   = 1'b1;
                    pval_d   = value;
                    pblank_d = blank_en;
                end
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    if (fblank_q && lead_q && (cur_nib == 4'h0) && (idx_q != '0)) begin
                        stage_d[idx_q] = 7'h7F;
                    end else begin
                        stage_d[idx_q] = dec_seg;
                        lead_d         = 1'b0;
                    end
                    if (idx_q != '0) begin
                        idx_d = idx_q - IDX_W'(1);
                        cnt_d = CNT_TOP;
                    end else begin
                        hex_d    = stage_q;
                        hex_d[0] = dec_seg;
                        state_d  = DONE;
                    end
                end
            end
            DONE: begin
                if (load) begin
                    start  = 1'b1;
                    pend_d = 1'b0;
                end else if (pend_q) begin
                    start       = 1'b1;
                    start_val   = pval_q;
                    start_blank = pblank_q;
                    pend_d      = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (start) begin
            frame_d  = start_val;
            fblank_d = start_blank;
            idx_d    = IDX_TOP;
            cnt_d    = CNT_TOP;
            lead_d   = 1'b1;
            state_d  = SCAN;
        end

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
        nib_d  = (state_d == SCAN) ? frame_d[idx_d] : 4'h0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            cnt_q    <= '0;
            lead_q   <= 1'b0;
            frame_q  <= '0;
            fblank_q <= 1'b0;
            pend_q   <= 1'b0;
            pval_q   <= '0;
            pblank_q <= 1'b0;
            stage_q  <= {NUM_DIGITS{7'h7F}};
            hex_q    <= {NUM_DIGITS{7'h7F}};
            nib_q    <= 4'h0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            lead_q   <= lead_d;
            frame_q  <= frame_d;
            fblank_q <= fblank_d;
            pend_q   <= pend_d;
            pval_q   <= pval_d;
            pblank_q <= pblank_d;
            stage_q  <= stage_d;
            hex_q    <= hex_d;
            nib_q    <= nib_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign dec_nibble = nib_q;
    assign hex_out    = hex_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_hex_scan_ctrl.sv
// Directed bench for hex_scan_ctrl: default instance with a combinational decoder,
// plus a SETTLE_CYCLES=3 instance driven by a two-register decoder.
module tb_hex_scan_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic [23:0] value, value3;
    logic        blank_en, blank3, load, load3;
    logic [6:0]  dec_seg, dec_seg3, dpipe1, dpipe2;
    logic [3:0]  dec_nibble, nib3;
    logic [41:0] hex_out, hex3;
    logic        busy, done, busy3, done3;

    int checks = 0;
    int errors = 0;

    localparam logic [41:0] ALL_ONES = {42{1'b1}};

    always #5 clock = ~clock;

    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'h0: return 7'h40; 4'h1: return 7'h79; 4'h2: return 7'h24; 4'h3: return 7'h30;
            4'h4: return 7'h19; 4'h5: return 7'h12; 4'h6: return 7'h02; 4'h7: return 7'h78;
            4'h8: return 7'h00; 4'h9: return 7'h10; 4'hA: return 7'h08; 4'hB: return 7'h03;
            4'hC: return 7'h46; 4'hD: return 7'h21; 4'hE: return 7'h06; default: return 7'h0E;
        endcase
    endfunction

    function automatic logic [41:0] pk(input logic [6:0] h5, h4, h3, h2, h1, h0);
        return {h5, h4, h3, h2, h1, h0};
    endfunction

    assign dec_seg = seg7(dec_nibble);

    // Decoder with two pipeline registers for the slow-settle instance.
    always @(posedge clock) begin
        dpipe1 <= seg7(nib3);
        dpipe2 <= dpipe1;
    end
    assign dec_seg3 = dpipe2;

    hex_scan_ctrl u_dut (
        .clock(clock), .reset(reset), .value(value), .blank_en(blank_en), .load(load),
        .dec_seg(dec_seg), .dec_nibble(dec_nibble), .hex_out(hex_out), .busy(busy), .done(done)
    );

    hex_scan_ctrl #(.NUM_DIGITS(6), .SETTLE_CYCLES(3)) u_dut3 (
        .clock(clock), .reset(reset), .value(value3), .blank_en(blank3), .load(load3),
        .dec_seg(dec_seg3), .dec_nibble(nib3), .hex_out(hex3), .busy(busy3), .done(done3)
    );

    // Loads one frame on the default instance and counts cycles until done (-1 on timeout).
    task automatic run_frame(input logic [23:0] v, input logic b, output int lat);
        value = v; blank_en = b; load = 1'b1;
        @(negedge clock);
        load = 1'b0;
        lat = -1;
        for (int c = 1; c <= 40; c++) begin
            if (done) begin
                lat = c;
                break;
            end
            @(negedge clock);
        end
    endtask

    task automatic test_reset();
        logic done_seen;
        reset = 1'b1; load = 1'b0; load3 = 1'b0; value = '0; value3 = '0;
        blank_en = 1'b0; blank3 = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        repeat (5) @(negedge clock);
        checks++; if (hex_out !== ALL_ONES) begin errors++; $display("FAIL reset_hex got %h exp %h", hex_out, ALL_ONES); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
        checks++; if (dec_nibble !== 4'h0) begin errors++; $display("FAIL reset_nibble got %h exp 0", dec_nibble); end

        // Abort a scan in its third cycle.
        value = 24'h777777; load = 1'b1;
        @(negedge clock); load = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b exp 0", busy); end
        checks++; if (hex_out !== ALL_ONES) begin errors++; $display("FAIL abort_hex got %h exp %h", hex_out, ALL_ONES); end
        checks++; if (dec_nibble !== 4'h0) begin errors++; $display("FAIL abort_nibble got %h exp 0", dec_nibble); end
        done_seen = 1'b0;
        for (int c = 0; c < 12; c++) begin
            if (done) done_seen = 1'b1;
            @(negedge clock);
        end
        checks++; if (done_seen !== 1'b0) begin errors++; $display("FAIL abort_done got %b exp 0", done_seen); end
        checks++; if (hex_out !== ALL_ONES) begin errors++; $display("FAIL abort_hex_late got %h exp %h", hex_out, ALL_ONES); end
    endtask

    task automatic test_basic();
        logic [3:0]  exp_n [6];
        logic [41:0] exp_hex;
        exp_n = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5};
        exp_hex = pk(7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12);
        value = 24'h012345; blank_en = 1'b0; load = 1'b1;
        @(negedge clock); load = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            checks++; if (dec_nibble !== exp_n[c-1]) begin errors++; $display("FAIL basic_nibble c%0d got %h exp %h", c, dec_nibble, exp_n[c-1]); end
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy c%0d got %b exp 1", c, busy); end
            checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_early c%0d got %b exp 0", c, done); end
            checks++; if (hex_out !== ALL_ONES) begin errors++; $display("FAIL basic_tear c%0d got %h exp %h", c, hex_out, ALL_ONES); end
            @(negedge clock);
        end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL basic_done got %b exp 1", done); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy7 got %b exp 1", busy); end
        checks++; if (hex_out !== exp_hex) begin errors++; $display("FAIL basic_hex got %h exp %h", hex_out, exp_hex); end
        checks++; if (dec_nibble !== 4'h0) begin errors++; $display("FAIL basic_nibble_done got %h exp 0", dec_nibble); end
        @(negedge clock);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got %b exp 0", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_idle got %b exp 0", busy); end
        checks++; if (hex_out !== exp_hex) begin errors++; $display("FAIL basic_hold got %h exp %h", hex_out, exp_hex); end
    endtask

    task automatic test_blank_zero();
        int lat;
        logic [41:0] exp_hex;
        exp_hex = pk(7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40);
        run_frame(24'h000000, 1'b1, lat);
        checks++; if (lat != 7) begin errors++; $display("FAIL blank0_latency got %0d exp 7", lat); end
        checks++; if (hex_out !== exp_hex) begin errors++; $display("FAIL blank0_hex got %h exp %h", hex_out, exp_hex); end
        @(negedge clock);
    endtask

    task automatic test_blank_interior();
        int lat;
        logic [41:0] exp_hex;
        exp_hex = pk(7'h7F, 7'h7F, 7'h08, 7'h40, 7'h30, 7'h40);
        run_frame(24'h00A030, 1'b1, lat);
        checks++; if (lat != 7) begin errors++; $display("FAIL blankint_latency got %0d exp 7", lat); end
        checks++; if (hex_out !== exp_hex) begin errors++; $display("FAIL blankint_hex got %h exp %h", hex_out, exp_hex); end
        @(negedge clock);
    endtask

    task automatic test_back_to_back();
        logic [41:0] hex9, hex2, hex1;
        int   done_cnt;
        logic seen1;
        hex9 = pk(7'h10, 7'h10, 7'h10, 7'h10, 7'h10, 7'h10);
        hex2 = pk(7'h24, 7'h24, 7'h24, 7'h24, 7'h24, 7'h24);
        hex1 = pk(7'h79, 7'h79, 7'h79, 7'h79, 7'h79, 7'h79);
        done_cnt = 0; seen1 = 1'b0;
        value = 24'h999999; blank_en = 1'b0; load = 1'b1;
        @(negedge clock); load = 1'b0;
        for (int c = 1; c <= 18; c++) begin
            if (done) done_cnt++;
            if (hex_out === hex1) seen1 = 1'b1;
            if (c == 7) begin
                checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_done1 got %b exp 1", done); end
                checks++; if (hex_out !== hex9) begin errors++; $display("FAIL b2b_hex1 got %h exp %h", hex_out, hex9); end
            end
            if (c == 8) begin
                checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_rescan got %b exp 1", busy); end
                checks++; if (dec_nibble !== 4'h2) begin errors++; $display("FAIL b2b_nibble got %h exp 2", dec_nibble); end
            end
            if (c == 14) begin
                checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_done2 got %b exp 1", done); end
                checks++; if (hex_out !== hex2) begin errors++; $display("FAIL b2b_hex2 got %h exp %h", hex_out, hex2); end
            end
            load  = (c == 2) || (c == 4);
            value = (c == 2) ? 24'h111111 : 24'h222222;
            @(negedge clock);
        end
        load = 1'b0;
        checks++; if (done_cnt != 2) begin errors++; $display("FAIL b2b_done_count got %0d exp 2", done_cnt); end
        checks++; if (seen1 !== 1'b0) begin errors++; $display("FAIL b2b_stale_frame got %b exp 0", seen1); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle got %b exp 0", busy); end
    endtask

    task automatic test_settle3();
        logic [3:0]  exp_n [6];
        logic [41:0] exp_hex;
        exp_n = '{4'hF, 4'hE, 4'hD, 4'hC, 4'hB, 4'hA};
        exp_hex = pk(7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08);
        value3 = 24'hFEDCBA; blank3 = 1'b0; load3 = 1'b1;
        @(negedge clock); load3 = 1'b0;
        for (int c = 1; c <= 18; c++) begin
            checks++; if (nib3 !== exp_n[(c-1)/3]) begin errors++; $display("FAIL s3_nibble c%0d got %h exp %h", c, nib3, exp_n[(c-1)/3]); end
            checks++; if (done3 !== 1'b0) begin errors++; $display("FAIL s3_done_early c%0d got %b exp 0", c, done3); end
            checks++; if (hex3 !== ALL_ONES) begin errors++; $display("FAIL s3_tear c%0d got %h exp %h", c, hex3, ALL_ONES); end
            @(negedge clock);
        end
        checks++; if (done3 !== 1'b1) begin errors++; $display("FAIL s3_done got %b exp 1", done3); end
        checks++; if (hex3 !== exp_hex) begin errors++; $display("FAIL s3_hex got %h exp %h", hex3, exp_hex); end
        checks++; if (busy3 !== 1'b1) begin errors++; $display("FAIL s3_busy got %b exp 1", busy3); end
        @(negedge clock);
        checks++; if (busy3 !== 1'b0) begin errors++; $display("FAIL s3_idle got %b exp 0", busy3); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_blank_zero();
        test_blank_interior();
        test_back_to_back();
        test_settle3();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got running exp finished");
        $fatal(1);
    end

endmodule
